// File: rtl/dadda_err_sweep.sv
// Exhaustive error sweep for an external combinational multiplier: issues every
// operand pair, compares the returned product with the exact one, accumulates stats.
module dadda_err_sweep #(
  parameter int WIDTH = 8,
  parameter int SUM_W = 4 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     mul_in1,
  output logic [WIDTH-1:0]     mul_in2,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic [2*WIDTH:0]     total_count,
  output logic [2*WIDTH:0]     err_count,
  output logic [SUM_W-1:0]     sum_ed,
  output logic [2*WIDTH-1:0]   max_ed,
  output logic [WIDTH-1:0]     max_in1,
  output logic [WIDTH-1:0]     max_in2,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_start_sweep;
  logic             w_last_pair;
  logic             r_drain_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_in2;
  logic             r_s1_valid;
  logic [PW-1:0]    r_s1_ed;
  logic [WIDTH-1:0] r_s1_in1;
  logic [WIDTH-1:0] r_s1_in2;
  logic [CW-1:0]    r_total;
  logic [CW-1:0]    r_err;
  logic [SUM_W-1:0] r_sum;
  logic [PW-1:0]    r_max;
  logic [WIDTH-1:0] r_max_in1;
  logic [WIDTH-1:0] r_max_in2;
  logic [PW-1:0]    w_exact;
  logic [PW-1:0]    w_ed;

  assign w_last_pair = (&r_in1) & (&r_in2);
  assign w_exact     = {{WIDTH{1'b0}}, r_in1} * {{WIDTH{1'b0}}, r_in2};
  assign w_ed        = (mul_prod >= w_exact) ? (mul_prod - w_exact) : (w_exact - mul_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_start_sweep = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next        = S_RUN;
          w_start_sweep = 1'b1;
        end
      end
      S_RUN:   if (w_last_pair) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= 1'b0;
      r_done      <= 1'b0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_ed     <= '0;
      r_s1_in1    <= '0;
      r_s1_in2    <= '0;
      r_total     <= '0;
      r_err       <= '0;
      r_sum       <= '0;
      r_max       <= '0;
      r_max_in1   <= '0;
      r_max_in2   <= '0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
      r_done      <= (r_state == S_DRAIN) && r_drain_cnt;
      // Stage 1 only captures while a pair is actually being presented.
      r_s1_valid  <= (r_state == S_RUN);
      r_s1_ed     <= w_ed;
      r_s1_in1    <= r_in1;
      r_s1_in2    <= r_in2;
      if (w_start_sweep) begin
        r_in1     <= '0;
        r_in2     <= '0;
        r_total   <= '0;
        r_err     <= '0;
        r_sum     <= '0;
        r_max     <= '0;
        r_max_in1 <= '0;
        r_max_in2 <= '0;
      end else begin
        if (r_state == S_RUN && !w_last_pair) begin
          r_in1 <= r_in1 + 1'b1;
          if (&r_in1) r_in2 <= r_in2 + 1'b1;
        end
        if (r_s1_valid) begin
          r_total <= r_total + CW'(1);
          r_err   <= r_err + CW'(r_s1_ed != '0);
          r_sum   <= r_sum + SUM_W'(r_s1_ed);
          // Strict compare so the earliest pair reaching the maximum is kept.
          if (r_s1_ed > r_max) begin
            r_max     <= r_s1_ed;
            r_max_in1 <= r_s1_in1;
            r_max_in2 <= r_s1_in2;
          end
        end
      end
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = r_done;
  assign mul_in1     = r_in1;
  assign mul_in2     = r_in2;
  assign total_count = r_total;
  assign err_count   = r_err;
  assign sum_ed      = r_sum;
  assign max_ed      = r_max;
  assign max_in1     = r_max_in1;
  assign max_in2     = r_max_in2;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dadda_err_sweep.sv
// Bench for dadda_err_sweep at a reduced operand width: several multiplier stubs,
// a loop-based reference of the error statistics, timing and abort checks.
module tb_dadda_err_sweep;

  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int SW = 4 * W;
  localparam int N  = 1 << (2 * W);
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  mul_in1;
  logic [W-1:0]  mul_in2;
  logic [PW-1:0] mul_prod;
  logic [PW:0]   total_count;
  logic [PW:0]   err_count;
  logic [SW-1:0] sum_ed;
  logic [PW-1:0] max_ed;
  logic [W-1:0]  max_in1;
  logic [W-1:0]  max_in2;
  logic [1:0]    dbg_state;

  int            total = 0;
  int            bad = 0;
  int            mode = 0;
  logic [PW-1:0] err_tab [N];

  dadda_err_sweep #(.WIDTH(W), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_prod(mul_prod),
    .total_count(total_count), .err_count(err_count), .sum_ed(sum_ed),
    .max_ed(max_ed), .max_in1(max_in1), .max_in2(max_in2), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Multiplier stubs: 0 exact, 1 bit0 forced low, 2 zero, 3 a*b+1, 4 exact xor random table.
  function automatic logic [PW-1:0] stub(input int m, input int a, input int b);
    logic [PW-1:0] p;
    p = PW'(a * b);
    case (m)
      0:       return p;
      1:       return p & ~PW'(1);
      2:       return '0;
      3:       return PW'(a * b + 1);
      default: return p ^ err_tab[b * M + a];
    endcase
  endfunction

  always @* mul_prod = stub(mode, int'(mul_in1), int'(mul_in2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int m, output longint tot, output longint errc, output longint sum,
                       output longint mx, output longint mx1, output longint mx2);
    longint ex, p, ed;
    tot = 0; errc = 0; sum = 0; mx = 0; mx1 = 0; mx2 = 0;
    for (int b = 0; b < M; b++) begin
      for (int a = 0; a < M; a++) begin
        ex = longint'(a * b);
        p  = longint'(stub(m, a, b));
        ed = (p > ex) ? p - ex : ex - p;
        tot++;
        if (ed != 0) errc++;
        sum += ed;
        if (ed > mx) begin
          mx = ed; mx1 = a; mx2 = b;
        end
      end
    end
  endtask

  task automatic sweep(input int m, input int pulse_at, input bit chk_order);
    longint etot, eerr, esum, emax, emx1, emx2;
    int done_at;
    int ord_bad;
    done_at = -1;
    ord_bad = 0;
    model(m, etot, eerr, esum, emax, emx1, emx2);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_at_start", 64'(busy), 64'd1);
    check("clear_at_start", 64'({total_count, err_count, sum_ed, max_ed}), 64'd0);
    for (int c = 0; c < N + 10 && done_at < 0; c++) begin
      if (chk_order && c < N && {mul_in2, mul_in1} !== PW'(c)) ord_bad++;
      if (c == pulse_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (done) done_at = c + 1;
    end
    check("done_cycle", 64'(done_at), 64'(N + 2));
    if (chk_order) check("issue_order", 64'(ord_bad), 64'd0);
    check("busy_at_done", 64'(busy), 64'd0);
    check("total_count", 64'(total_count), 64'(etot));
    check("err_count", 64'(err_count), 64'(eerr));
    check("sum_ed", 64'(sum_ed), 64'(esum));
    check("max_ed", 64'(max_ed), 64'(emax));
    check("max_pair", 64'({max_in2, max_in1}), 64'({emx2[W-1:0], emx1[W-1:0]}));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("held_stats", 64'({total_count, sum_ed}), {31'd0, etot[PW:0], esum[SW-1:0]});
    check("held_operands", 64'({mul_in2, mul_in1}), 64'(N - 1));
  endtask

  task automatic abort_sweep(input int at_cycle);
    int done_seen;
    done_seen = 0;
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (at_cycle) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_outputs_zero",
          64'({busy, done, mul_in1, mul_in2, total_count, err_count, sum_ed, max_ed, max_in1, max_in2}),
          64'd0);
    check("abort_state_idle", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < N + 10; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({busy, done, mul_in1, mul_in2, total_count, err_count, sum_ed, max_ed, max_in1, max_in2}),
          64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_not_busy", 64'(busy), 64'd0);

    sweep(0, -1, 1'b1);
    sweep(1, -1, 1'b0);
    sweep(2, -1, 1'b0);
    sweep(3, 100, 1'b0);
    abort_sweep(100);
    sweep(0, -1, 1'b0);

    for (int r = 0; r < 2; r++) begin
      mode = 0;
      for (int i = 0; i < N; i++)
        err_tab[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(1, (1 << PW) - 1)) : '0;
      sweep(4, -1, 1'b1);
      sweep(4, int'($urandom_range(5, N - 5)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
